player_ctl: RTL and testbench

//  Player motion controller: upstream of the player-drawing stage; supplies the

---
 rtl/player_ctl.sv | 136 +++++++++++++
 tb/tb_player_ctl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctl.sv
// Player motion controller: samples buttons, moves with clamping and runs a
// jump/gravity FSM, updating position once per frame at the start of vertical blank.
module player_ctl #(
  parameter int X_START  = 320,
  parameter int H_MIN    = 0,
  parameter int H_MAX    = 976,
  parameter int GROUND_Y = 600,
  parameter int V_MIN    = 0,
  parameter int SPEED    = 4,
  parameter int JUMP_V0  = 16,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        in_air,
  output logic        facing_left
);

  localparam logic [0:0] ST_GROUND = 1'b0;
  localparam logic [0:0] ST_AIR    = 1'b1;

  localparam logic signed [12:0] SPD_S  = 13'(SPEED);
  localparam logic signed [12:0] HMIN_S = 13'(H_MIN);
  localparam logic signed [12:0] HMAX_S = 13'(H_MAX);
  localparam logic signed [12:0] GND_S  = 13'(GROUND_Y);
  localparam logic signed [12:0] VMIN_S = 13'(V_MIN);
  localparam logic signed [7:0]  V0_S   = 8'(-JUMP_V0);
  localparam logic signed [7:0]  GRAV_S = 8'(GRAVITY);
  localparam logic signed [7:0]  VMAX_S = 8'(VMAX);
  localparam logic [11:0]        X0     = 12'(X_START);
  localparam logic [11:0]        XMIN   = 12'(H_MIN);
  localparam logic [11:0]        XMAX   = 12'(H_MAX);
  localparam logic [11:0]        Y0     = 12'(GROUND_Y);
  localparam logic [11:0]        YMIN   = 12'(V_MIN);

  logic [0:0]         state, state_n;
  logic signed [7:0]  vel, vel_n, vel_inc;
  logic [11:0]        x_n, y_n;
  logic               face_n;
  logic               vblnk_q, jump_q, jump_req;
  logic               tick, jump_rise, want_jump;
  logic signed [12:0] x_left, x_right, y_sum;

  always_comb begin
    tick      = vblnk & ~vblnk_q;
    jump_rise = btn_jump & ~jump_q;
    want_jump = jump_req | jump_rise;

    // 13-bit signed arithmetic so moving left past zero clamps instead of wrapping
    x_left  = $signed({1'b0, xpos}) - SPD_S;
    x_right = $signed({1'b0, xpos}) + SPD_S;
    y_sum   = $signed({1'b0, ypos}) + $signed({{5{vel[7]}}, vel});
    vel_inc = vel + GRAV_S;
    if (vel_inc > VMAX_S) vel_inc = VMAX_S;

    x_n     = xpos;
    face_n  = facing_left;
    y_n     = ypos;
    vel_n   = vel;
    state_n = state;

    case ({btn_left, btn_right})
      2'b10: begin
        x_n    = (x_left < HMIN_S) ? XMIN : x_left[11:0];
        face_n = 1'b1;
      end
      2'b01: begin
        x_n    = (x_right > HMAX_S) ? XMAX : x_right[11:0];
        face_n = 1'b0;
      end
      default: ;
    endcase

    case (state)
      ST_GROUND: begin
        y_n = Y0;
        if (want_jump) begin
          vel_n   = V0_S;
          state_n = ST_AIR;
        end else begin
          vel_n = 8'sd0;
        end
      end
      default: begin
        // Landing tick never starts a new jump; the request is simply dropped
        if (y_sum >= GND_S) begin
          y_n     = Y0;
          vel_n   = 8'sd0;
          state_n = ST_GROUND;
        end else if (y_sum < VMIN_S) begin
          y_n   = YMIN;
          vel_n = 8'sd0;
        end else begin
          y_n   = y_sum[11:0];
          vel_n = vel_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xpos        <= X0;
      ypos        <= Y0;
      vel         <= 8'sd0;
      state       <= ST_GROUND;
      in_air      <= 1'b0;
      facing_left <= 1'b0;
      vblnk_q     <= 1'b1;
      jump_q      <= 1'b1;
      jump_req    <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      jump_q  <= btn_jump;
      if (tick) begin
        xpos        <= x_n;
        ypos        <= y_n;
        vel         <= vel_n;
        state       <= state_n;
        in_air      <= (state_n == ST_AIR);
        facing_left <= face_n;
        jump_req    <= 1'b0;
      end else if (jump_rise) begin
        jump_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_player_ctl.sv
// Bench for player_ctl: directed frame scenarios plus randomized buttons/resets,
// all checked every cycle against an integer behavioural model.
module tb_player_ctl;

  localparam int X_START  = 320;
  localparam int H_MIN    = 0;
  localparam int H_MAX    = 976;
  localparam int GROUND_Y = 600;
  localparam int V_MIN    = 0;
  localparam int SPEED    = 4;
  localparam int JUMP_V0  = 16;
  localparam int GRAVITY  = 1;
  localparam int VMAX     = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vblnk = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_jump = 1'b0;
  logic [11:0] xpos, ypos;
  logic        in_air, facing_left;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  player_ctl dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .xpos(xpos), .ypos(ypos), .in_air(in_air), .facing_left(facing_left)
  );

  // Behavioural model: frame-level motion rules on plain integers
  int m_x = X_START, m_y = GROUND_Y, m_v = 0;
  bit m_air = 0, m_face = 0, m_req = 0, m_prev_vb = 1, m_prev_jb = 1;

  always @(posedge clk) begin : model
    bit rise, frame_start, want;
    int yn;
    if (!rst) begin
      m_x = X_START; m_y = GROUND_Y; m_v = 0; m_air = 0; m_face = 0;
      m_req = 0; m_prev_vb = 1; m_prev_jb = 1;
    end else begin
      rise        = btn_jump && !m_prev_jb;
      frame_start = vblnk && !m_prev_vb;
      if (frame_start) begin
        if (btn_left && !btn_right) begin
          m_x = (m_x - SPEED < H_MIN) ? H_MIN : m_x - SPEED;
          m_face = 1;
        end else if (btn_right && !btn_left) begin
          m_x = (m_x + SPEED > H_MAX) ? H_MAX : m_x + SPEED;
          m_face = 0;
        end
        want = m_req || rise;
        if (!m_air) begin
          m_y = GROUND_Y;
          if (want) begin m_v = -JUMP_V0; m_air = 1; end
          else m_v = 0;
        end else begin
          yn = m_y + m_v;
          if (yn >= GROUND_Y) begin m_y = GROUND_Y; m_v = 0; m_air = 0; end
          else if (yn < V_MIN) begin m_y = V_MIN; m_v = 0; end
          else begin m_y = yn; m_v = (m_v + GRAVITY > VMAX) ? VMAX : m_v + GRAVITY; end
        end
        m_req = 0;
      end else if (rise) begin
        m_req = 1;
      end
      m_prev_vb = vblnk;
      m_prev_jb = btn_jump;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("mdl_xpos", int'(xpos), m_x);
      chk("mdl_ypos", int'(ypos), m_y);
      chk("mdl_in_air", int'(in_air), int'(m_air));
      chk("mdl_facing", int'(facing_left), int'(m_face));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One frame: lo cycles of active video then hi cycles of blank.
  // Optional one-cycle reset and jump button on/off at given cycle indices.
  task automatic frame(input int lo, input int hi, input bit rnd,
                       input int rst_cyc, input int jp_on, input int jp_off);
    for (int i = 0; i < lo + hi; i++) begin
      vblnk = (i >= lo);
      rst   = (i == rst_cyc) ? 1'b0 : 1'b1;
      if (i == jp_on)  btn_jump = 1'b1;
      if (i == jp_off) btn_jump = 1'b0;
      if (rnd) begin
        if ($urandom_range(0, 5) == 0) btn_left  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) btn_right = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) btn_jump  = 1'($urandom_range(0, 1));
      end
      step();
    end
    vblnk = 1'b0;
    rst   = 1'b1;
  endtask

  task automatic plain(input int n);
    for (int k = 0; k < n; k++) frame(2, 1, 1'b0, -1, -1, -1);
  endtask

  task automatic wait_land(input string tag);
    int n;
    n = 0;
    while (in_air && n < 60) begin
      frame(8, 4, 1'b0, -1, -1, -1);
      @(negedge clk);
      n++;
    end
    if (in_air) chk(tag, 0, 1);
  endtask

  initial begin
    rst = 1'b0;
    step();
    check_en = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_xpos", int'(xpos), 320);
    chk("rst_ypos", int'(ypos), 600);
    chk("rst_in_air", int'(in_air), 0);
    chk("rst_facing", int'(facing_left), 0);
    rst = 1'b1;

    // Walk right three frames
    btn_right = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      frame(8, 4, 1'b0, -1, -1, -1);
      @(negedge clk);
      chk("t1_xpos", int'(xpos), 320 + 4 * k);
      chk("t1_facing", int'(facing_left), 0);
    end

    // Both buttons: no motion, facing kept
    btn_left = 1'b1;
    frame(8, 4, 1'b0, -1, -1, -1);
    frame(8, 4, 1'b0, -1, -1, -1);
    @(negedge clk);
    chk("t4_xpos", int'(xpos), 332);
    chk("t4_facing", int'(facing_left), 0);
    btn_right = 1'b0;
    frame(8, 4, 1'b0, -1, -1, -1);
    @(negedge clk);
    chk("t4_left_xpos", int'(xpos), 328);
    chk("t4_left_facing", int'(facing_left), 1);

    // Left clamp at H_MIN
    plain(90);
    @(negedge clk);
    chk("t2_xpos_min", int'(xpos), 0);
    chk("t2_facing", int'(facing_left), 1);

    // Right clamp at H_MAX
    btn_left  = 1'b0;
    btn_right = 1'b1;
    plain(250);
    @(negedge clk);
    chk("t3_xpos_max", int'(xpos), 976);
    plain(3);
    @(negedge clk);
    chk("t3_xpos_hold", int'(xpos), 976);
    chk("t3_facing", int'(facing_left), 0);
    btn_right = 1'b0;

    // Jump pulse mid-frame
    frame(8, 4, 1'b0, -1, 2, 4);
    @(negedge clk);
    chk("t5_in_air", int'(in_air), 1);
    chk("t5_ypos0", int'(ypos), 600);
    exp_q.push_back(12'd584);
    exp_q.push_back(12'd569);
    exp_q.push_back(12'd555);
    while (exp_q.size() > 0) begin
      frame(8, 4, 1'b0, -1, -1, -1);
      @(negedge clk);
      chk("t5_arc_ypos", int'(ypos), int'(exp_q.pop_front()));
    end
    wait_land("t5_land_timeout");
    chk("t5_land_ypos", int'(ypos), 600);
    chk("t5_land_in_air", int'(in_air), 0);

    // Jump held through landing: no re-jump
    frame(8, 4, 1'b0, -1, 2, -1);
    @(negedge clk);
    chk("t6_in_air", int'(in_air), 1);
    wait_land("t6_land_timeout");
    frame(8, 4, 1'b0, -1, -1, -1);
    frame(8, 4, 1'b0, -1, -1, -1);
    @(negedge clk);
    chk("t6_no_rejump", int'(in_air), 0);
    // Release, then press exactly on the blank edge
    frame(8, 4, 1'b0, -1, 8, 1);
    @(negedge clk);
    chk("t6_rejump", int'(in_air), 1);

    // Reset during blank mid-jump with buttons held
    frame(8, 4, 1'b0, -1, -1, -1);
    btn_right = 1'b1;
    btn_jump  = 1'b1;
    frame(8, 6, 1'b0, 10, -1, -1);
    @(negedge clk);
    chk("t7_xpos", int'(xpos), 320);
    chk("t7_ypos", int'(ypos), 600);
    chk("t7_in_air", int'(in_air), 0);
    frame(8, 4, 1'b0, -1, -1, -1);
    @(negedge clk);
    chk("t7_resume_xpos", int'(xpos), 324);
    chk("t7_no_false_jump", int'(in_air), 0);
    btn_right = 1'b0;
    btn_jump  = 1'b0;

    // Randomized frames, buttons and occasional resets
    for (int f = 0; f < 300; f++) begin
      frame($urandom_range(2, 12), $urandom_range(1, 5), 1'b1,
            ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1, -1, -1);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
